cdc_fifo_wr_arbiter: RTL and testbench

// Round-robin arbiter sharing the write port of the async CDC FIFO among
// NUM_REQ valid/ready requesters in the write clock domain. Grants one

---
 rtl/cdc_fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_cdc_fifo_wr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_wr_arbiter.sv
// Round-robin arbiter for the write port of the async CDC FIFO.
// One requester at a time owns the port for a burst of up to BURST_LEN beats.
// Each accepted word is registered onto w_inc/w_data. Writes are throttled on
// w_full/w_almost_full, so the FIFO never receives a write it would drop.
//
// Optional feature: define CDC_FIFO_WR_ARB_TAG_EN to prefix each written word
// with the index of the requester that sent it (w_data = {grant_idx, word}).
//
// state | meaning
// IDLE  | no owner; pick the next valid requester round-robin (1 cycle)
// LOCK  | burst owner may push words while the FIFO has room
module cdc_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int IDX_W     = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
`ifdef CDC_FIFO_WR_ARB_TAG_EN
  localparam int W_OUT     = DATA_WIDTH + IDX_W
`else
  localparam int W_OUT     = DATA_WIDTH
`endif
) (
  input  logic                          w_clk,
  input  logic                          w_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          w_full,
  input  logic                          w_almost_full,
  output logic                          w_inc,
  output logic [W_OUT-1:0]              w_data,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0]  words [NUM_REQ];
  logic [DATA_WIDTH-1:0]  owner_word;
  logic                   owner_valid;
  logic                   can_write;
  logic                   accept;
  logic                   last_beat;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       rr_next;

  // Unpack the flat requester data bus so it can be indexed by grant_idx.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The in-flight registered write consumes the last free slot when almost full.
  assign can_write   = !w_full && !(w_almost_full && w_inc);
  assign owner_valid = req_valid[grant_idx];
  assign owner_word  = words[grant_idx];
  assign accept      = (state_q == LOCK) && owner_valid && can_write;
  assign last_beat   = (cnt_q == CNT_W'(BURST_LEN - 1));
  assign busy        = (state_q == LOCK);
  assign rr_next     = IDX_W'((int'(pick_idx) + 1) % NUM_REQ);

  // Round-robin search: first valid requester starting at the RR pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_q) + i) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and ready generation.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) state_d = LOCK;
      end
      LOCK: begin
        req_ready[grant_idx] = can_write;
        if (!owner_valid) state_d = IDLE;
        else if (accept && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Grant owner, RR pointer and burst beat counter.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      grant_idx <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
    end else if (state_q == IDLE) begin
      if (pick_found) begin
        grant_idx <= pick_idx;
        rr_q      <= rr_next;
        cnt_q     <= '0;
      end
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Push pipeline: one registered write per accepted word, in accept order.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_inc  <= 1'b0;
      w_data <= '0;
    end else begin
      w_inc <= accept;
      if (accept) begin
`ifdef CDC_FIFO_WR_ARB_TAG_EN
        w_data <= {grant_idx, owner_word};
`else
        w_data <= owner_word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Directed bench for cdc_fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
// Inputs are driven on the falling edge and all outputs checked 1ns later.
module tb_cdc_fifo_wr_arbiter;

`ifdef CDC_FIFO_WR_ARB_TAG_EN
  localparam int W_OUT = 10;
`else
  localparam int W_OUT = 8;
`endif

  logic             w_clk = 1'b0;
  logic             w_rst_n = 1'b0;
  logic [3:0]       req_valid = '0;
  logic [31:0]      req_data = '0;
  logic [3:0]       req_ready;
  logic             w_full = 1'b0;
  logic             w_almost_full = 1'b0;
  logic             w_inc;
  logic [W_OUT-1:0] w_data;
  logic [1:0]       grant_idx;
  logic             busy;

  int checks = 0;
  int failures = 0;

  cdc_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .w_full(w_full), .w_almost_full(w_almost_full),
    .w_inc(w_inc), .w_data(w_data), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        full;
    logic        af;
    logic [3:0]  rdy;
    logic        inc;
    logic [1:0]  wt;
    logic [7:0]  wd;
    logic [1:0]  gi;
    logic        bsy;
  } vec_t;

  vec_t vecs [35];

  function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] dat,
                              input logic full, input logic af, input logic [3:0] rdy,
                              input logic inc, input logic [1:0] wt, input logic [7:0] wd,
                              input logic [1:0] gi, input logic bsy);
    vec_t v;
    v.vld = vld; v.dat = dat; v.full = full; v.af = af; v.rdy = rdy;
    v.inc = inc; v.wt = wt; v.wd = wd; v.gi = gi; v.bsy = bsy;
    return v;
  endfunction

  // Expected w_data: tag bits only survive when the tagged build is used.
  function automatic logic [31:0] xwd(input logic [1:0] t, input logic [7:0] d);
    logic [31:0] full_word;
    full_word = {22'd0, t, d};
    return full_word & ((32'd1 << W_OUT) - 32'd1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    int own;
    logic       e_inc;
    logic [1:0] e_wt;
    logic [7:0] e_wd;
    logic       lock;

    // Single requester, 6 words: 4-beat burst, re-arbitrate, 2 more beats.
    vecs[0]  = mk(4'b0001, 32'h01, 0, 0, 4'b0000, 0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(4'b0001, 32'h01, 0, 0, 4'b0001, 0, 0, 8'h00, 0, 1);
    vecs[2]  = mk(4'b0001, 32'h02, 0, 0, 4'b0001, 1, 0, 8'h01, 0, 1);
    vecs[3]  = mk(4'b0001, 32'h03, 0, 0, 4'b0001, 1, 0, 8'h02, 0, 1);
    vecs[4]  = mk(4'b0001, 32'h04, 0, 0, 4'b0001, 1, 0, 8'h03, 0, 1);
    vecs[5]  = mk(4'b0001, 32'h05, 0, 0, 4'b0000, 1, 0, 8'h04, 0, 0);
    vecs[6]  = mk(4'b0001, 32'h05, 0, 0, 4'b0001, 0, 0, 8'h04, 0, 1);
    vecs[7]  = mk(4'b0001, 32'h06, 0, 0, 4'b0001, 1, 0, 8'h05, 0, 1);
    vecs[8]  = mk(4'b0000, 32'h06, 0, 0, 4'b0001, 1, 0, 8'h06, 0, 1);
    vecs[9]  = mk(4'b0000, 32'h06, 0, 0, 4'b0000, 0, 0, 8'h06, 0, 0);
    // Owner 0 drops after 2 beats; req1 then gets a full 4-beat burst.
    vecs[10] = mk(4'b0001, 32'h2111, 0, 0, 4'b0000, 0, 0, 8'h06, 0, 0);
    vecs[11] = mk(4'b0011, 32'h2111, 0, 0, 4'b0001, 0, 0, 8'h06, 0, 1);
    vecs[12] = mk(4'b0011, 32'h2112, 0, 0, 4'b0001, 1, 0, 8'h11, 0, 1);
    vecs[13] = mk(4'b0010, 32'h2100, 0, 0, 4'b0001, 1, 0, 8'h12, 0, 1);
    vecs[14] = mk(4'b0010, 32'h2100, 0, 0, 4'b0000, 0, 0, 8'h12, 0, 0);
    vecs[15] = mk(4'b0010, 32'h2100, 0, 0, 4'b0010, 0, 0, 8'h12, 1, 1);
    vecs[16] = mk(4'b0010, 32'h2200, 0, 0, 4'b0010, 1, 1, 8'h21, 1, 1);
    vecs[17] = mk(4'b0010, 32'h2300, 0, 0, 4'b0010, 1, 1, 8'h22, 1, 1);
    vecs[18] = mk(4'b0010, 32'h2400, 0, 0, 4'b0010, 1, 1, 8'h23, 1, 1);
    vecs[19] = mk(4'b0000, 32'h2400, 0, 0, 4'b0000, 1, 1, 8'h24, 1, 0);
    vecs[20] = mk(4'b0000, 32'h0,    0, 0, 4'b0000, 0, 1, 8'h24, 1, 0);
    // Req2: A5 word, almost-full throttle, then 5 cycles of full.
    vecs[21] = mk(4'b0100, 32'hA50000, 0, 0, 4'b0000, 0, 1, 8'h24, 1, 0);
    vecs[22] = mk(4'b0100, 32'hA50000, 0, 0, 4'b0100, 0, 1, 8'h24, 2, 1);
    vecs[23] = mk(4'b0100, 32'h320000, 0, 1, 4'b0000, 1, 2, 8'hA5, 2, 1);
    vecs[24] = mk(4'b0100, 32'h320000, 0, 1, 4'b0100, 0, 2, 8'hA5, 2, 1);
    vecs[25] = mk(4'b0100, 32'h330000, 0, 1, 4'b0000, 1, 2, 8'h32, 2, 1);
    vecs[26] = mk(4'b0100, 32'h330000, 1, 0, 4'b0000, 0, 2, 8'h32, 2, 1);
    vecs[27] = mk(4'b0100, 32'h330000, 1, 0, 4'b0000, 0, 2, 8'h32, 2, 1);
    vecs[28] = mk(4'b0100, 32'h330000, 1, 0, 4'b0000, 0, 2, 8'h32, 2, 1);
    vecs[29] = mk(4'b0100, 32'h330000, 1, 0, 4'b0000, 0, 2, 8'h32, 2, 1);
    vecs[30] = mk(4'b0100, 32'h330000, 1, 0, 4'b0000, 0, 2, 8'h32, 2, 1);
    vecs[31] = mk(4'b0100, 32'h330000, 0, 0, 4'b0100, 0, 2, 8'h32, 2, 1);
    vecs[32] = mk(4'b0100, 32'h340000, 0, 0, 4'b0100, 1, 2, 8'h33, 2, 1);
    vecs[33] = mk(4'b0000, 32'h0,      0, 0, 4'b0000, 1, 2, 8'h34, 2, 0);
    vecs[34] = mk(4'b0000, 32'h0,      0, 0, 4'b0000, 0, 2, 8'h34, 2, 0);

    // Reset values.
    @(negedge w_clk); #1;
    chk("rst_w_inc", 32'(w_inc), 0);
    chk("rst_w_data", 32'(w_data), 0);
    chk("rst_grant_idx", 32'(grant_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    @(negedge w_clk);
    w_rst_n = 1'b1;

    // Table-driven part.
    for (int k = 0; k < 35; k++) begin
      @(negedge w_clk);
      req_valid = vecs[k].vld;
      req_data = vecs[k].dat;
      w_full = vecs[k].full;
      w_almost_full = vecs[k].af;
      #1;
      chk($sformatf("v%0d_req_ready", k), 32'(req_ready), 32'(vecs[k].rdy));
      chk($sformatf("v%0d_w_inc", k), 32'(w_inc), 32'(vecs[k].inc));
      chk($sformatf("v%0d_w_data", k), 32'(w_data), xwd(vecs[k].wt, vecs[k].wd));
      chk($sformatf("v%0d_grant_idx", k), 32'(grant_idx), 32'(vecs[k].gi));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].bsy));
      if (w_inc && w_full) chk($sformatf("v%0d_inc_while_full", k), 1, 0);
    end

    // All four valid, no backpressure: RR pointer is at 3 after the table.
    e_inc = 1'b0;
    e_wt = 2'd2;
    e_wd = 8'h34;
    for (int b = 0; b < 5; b++) begin
      own = (3 + b) % 4;
      for (int c = 0; c < 5; c++) begin
        @(negedge w_clk);
        req_valid = 4'b1111;
        req_data = 32'h43424140;
        w_full = 1'b0;
        w_almost_full = 1'b0;
        #1;
        lock = (c != 0);
        chk($sformatf("rr_b%0d_c%0d_ready", b, c), 32'(req_ready),
            lock ? (32'd1 << own) : 32'd0);
        chk($sformatf("rr_b%0d_c%0d_busy", b, c), 32'(busy), 32'(lock));
        if (lock) chk($sformatf("rr_b%0d_c%0d_grant", b, c), 32'(grant_idx), 32'(own));
        chk($sformatf("rr_b%0d_c%0d_w_inc", b, c), 32'(w_inc), 32'(e_inc));
        chk($sformatf("rr_b%0d_c%0d_w_data", b, c), 32'(w_data), xwd(e_wt, e_wd));
        chk($sformatf("rr_b%0d_c%0d_onehot", b, c), 32'($countones(req_ready) <= 1), 1);
        if (lock) begin
          e_inc = 1'b1;
          e_wt = 2'(own);
          e_wd = 8'h40 + 8'(own);
        end else begin
          e_inc = 1'b0;
        end
      end
    end

    // Reset in the middle of a burst owned by req3 (RR pointer now 0).
    @(negedge w_clk);
    req_valid = 4'b1000;
    #1;
    chk("mid_idle_w_inc", 32'(w_inc), 1);
    chk("mid_idle_busy", 32'(busy), 0);
    @(negedge w_clk); #1;
    chk("mid_grant3", 32'(grant_idx), 3);
    chk("mid_ready3", 32'(req_ready), 32'b1000);
    @(negedge w_clk); #1;
    chk("mid_beat1_w_inc", 32'(w_inc), 1);
    chk("mid_beat1_w_data", 32'(w_data), xwd(2'd3, 8'h43));
    @(negedge w_clk);
    w_rst_n = 1'b0;
    #1;
    chk("rst_mid_w_inc", 32'(w_inc), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_grant_idx", 32'(grant_idx), 0);
    chk("rst_mid_w_data", 32'(w_data), 0);
    chk("rst_mid_ready", 32'(req_ready), 0);
    @(negedge w_clk);
    req_valid = 4'b0110;
    w_rst_n = 1'b1;
    #1;
    chk("post_rst_idle_busy", 32'(busy), 0);
    chk("post_rst_idle_ready", 32'(req_ready), 0);
    @(negedge w_clk); #1;
    chk("post_rst_grant1", 32'(grant_idx), 1);
    chk("post_rst_busy", 32'(busy), 1);
    chk("post_rst_ready1", 32'(req_ready), 32'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
